// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV store-side packers: packer FSM states, lane math and pad default.
package spmv_pkg;

  typedef enum logic [2:0] {
    StAccum,
    StFill,
    StFlushWord,
    StFlushPair,
    StDone
  } state_e;

  localparam int unsigned PadValueDefault = 0;

  function automatic int unsigned lanes_per_beat(input int unsigned data_w,
                                                 input int unsigned val_w);
    return data_w / val_w;
  endfunction

endpackage

// File: rtl/stq_beat_reg.sv
// Single-entry valid/ready holding register for store-queue beats, with a running beat id
// that advances on every accepted beat.
module stq_beat_reg #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ID_WIDTH-1:0]   out_id_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  drain;

  // Draining and loading in the same cycle keeps the register full with no bubble.
  assign drain      = valid_q & out_ready_i;
  assign in_ready_o = ~valid_q | out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    if (drain) begin
      valid_d = 1'b0;
      id_d    = id_q + ID_WIDTH'(1);
    end
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_id_o    = id_q;

endmodule

// File: rtl/spmv_result_packer.sv
// Packs per-row SpMV results into store-queue beats, padding row gaps, the final partial beat
// and an odd beat count so the store queue always receives beat pairs.
module spmv_result_packer
  import spmv_pkg::*;
#(
  parameter int unsigned         VAL_WIDTH      = 32,
  parameter int unsigned         STQ_DATA_WIDTH = 256,
  parameter int unsigned         ROW_WIDTH      = 32,
  parameter logic [VAL_WIDTH-1:0] PAD_VALUE     = VAL_WIDTH'(PadValueDefault)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROW_WIDTH-1:0]      in_row,
  input  logic [VAL_WIDTH-1:0]      in_val,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_id,
  output logic [STQ_DATA_WIDTH-1:0] out_data,
  output logic                      done,
  output logic                      err_seq
);

  localparam int unsigned LANES = lanes_per_beat(STQ_DATA_WIDTH, VAL_WIDTH);
  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(LANES - 1);

  state_e                           state_q, state_d;
  logic [ROW_WIDTH-1:0]             exp_row_q, exp_row_d, exp_row_inc;
  logic [LaneW-1:0]                 lane_cnt_q, lane_cnt_d;
  logic                             parity_q, parity_d;
  logic [LANES-1:0][VAL_WIDTH-1:0]  buf_q, buf_d;
  logic                             err_seq_q, err_seq_d;

  logic                             accept;
  logic                             wr_en;
  logic [VAL_WIDTH-1:0]             wr_val;
  logic                             load;
  logic [STQ_DATA_WIDTH-1:0]        load_data;
  logic                             beat_ready;
  logic                             can_take;

  assign exp_row_inc = exp_row_q + ROW_WIDTH'(1);
  // The last lane only completes a beat if the output register can take it this cycle.
  assign can_take    = (lane_cnt_q != LastLane) | beat_ready;

  always_comb begin
    state_d    = state_q;
    exp_row_d  = exp_row_q;
    lane_cnt_d = lane_cnt_q;
    parity_d   = parity_q;
    buf_d      = buf_q;
    err_seq_d  = err_seq_q;
    accept     = 1'b0;
    wr_en      = 1'b0;
    wr_val     = PAD_VALUE;
    load       = 1'b0;
    load_data  = buf_q;

    unique case (state_q)
      StAccum: begin
        if (in_valid) begin
          if (in_row == exp_row_q) begin
            if (can_take) begin
              accept = 1'b1;
              wr_en  = 1'b1;
              wr_val = in_val;
              if (in_last) begin
                state_d = (lane_cnt_q == LastLane) ? StFlushPair : StFlushWord;
              end
            end
          end else if (in_row < exp_row_q) begin
            accept    = 1'b1;
            err_seq_d = 1'b1;
          end else begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (!in_valid || in_row == exp_row_q) begin
          state_d = StAccum;
        end else if (can_take) begin
          wr_en = 1'b1;
          if (in_row == exp_row_inc) state_d = StAccum;
        end
      end
      StFlushWord: begin
        if (can_take) begin
          wr_en = 1'b1;
          if (lane_cnt_q == LastLane) state_d = StFlushPair;
        end
      end
      StFlushPair: begin
        if (parity_q) begin
          if (beat_ready) begin
            load      = 1'b1;
            load_data = {LANES{PAD_VALUE}};
          end
        end else if (!out_valid) begin
          state_d = StDone;
        end
      end
      StDone: begin
        exp_row_d  = '0;
        lane_cnt_d = '0;
        parity_d   = 1'b0;
        state_d    = StAccum;
      end
      default: state_d = StAccum;
    endcase

    if (wr_en) begin
      buf_d[lane_cnt_q] = wr_val;
      lane_cnt_d        = lane_cnt_q + LaneW'(1);
      exp_row_d         = exp_row_inc;
      if (lane_cnt_q == LastLane) begin
        load      = 1'b1;
        load_data = buf_d;
      end
    end
    if (load) parity_d = ~parity_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StAccum;
      exp_row_q  <= '0;
      lane_cnt_q <= '0;
      parity_q   <= 1'b0;
      buf_q      <= '0;
      err_seq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_row_q  <= exp_row_d;
      lane_cnt_q <= lane_cnt_d;
      parity_q   <= parity_d;
      buf_q      <= buf_d;
      err_seq_q  <= err_seq_d;
    end
  end

  stq_beat_reg #(
    .DATA_WIDTH(STQ_DATA_WIDTH),
    .ID_WIDTH  (8)
  ) u_beat_reg (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .in_valid_i (load),
    .in_ready_o (beat_ready),
    .in_data_i  (load_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_id_o   (out_id)
  );

  assign in_ready = accept & ~sys_rst;
  assign done     = (state_q == StDone);
  assign err_seq  = err_seq_q;

endmodule

// File: tb/tb_spmv_result_packer.sv
// Scoreboard bench for spmv_result_packer: a list-level model predicts every beat, a monitor
// checks beats, id order, stall stability and done pulses as the DUT presents them.
module tb_spmv_result_packer;

  localparam int VW = 32;
  localparam int DW = 256;
  localparam int RW = 32;
  localparam int LN = DW / VW;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] in_row = '0;
  logic [VW-1:0] in_val = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_id;
  logic [DW-1:0] out_data;
  logic          done;
  logic          err_seq;

  spmv_result_packer #(
    .VAL_WIDTH     (VW),
    .STQ_DATA_WIDTH(DW),
    .ROW_WIDTH     (RW),
    .PAD_VALUE     ('0)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .in_val   (in_val),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_id   (out_id),
    .out_data (out_data),
    .done     (done),
    .err_seq  (err_seq)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0]    id;
    logic [DW-1:0] data;
  } beat_t;

  int          n_tests = 0;
  int          n_fail = 0;
  beat_t       exp_q[$];
  logic [7:0]  id_ctr = '0;
  bit          err_model = 1'b0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          stall_until = 0;
  bit          rand_ready = 1'b0;
  int unsigned rows[64];
  logic [31:0] vals[64];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  initial forever begin
    @(posedge sys_clk);
    #1;
    if (cyc < stall_until) out_ready = 1'b0;
    else if (rand_ready) out_ready = ($urandom_range(3) != 0);
    else out_ready = 1'b1;
  end

  // Monitor: beat scoreboard, stall stability and done accounting.
  initial begin
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [7:0]    prev_id;
    beat_t         b;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_id    = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", DW'(out_valid), DW'(1));
          check("hold_data", out_data, prev_data);
          check("hold_id", DW'(out_id), DW'(prev_id));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat_id", DW'(out_id), DW'(9'h100));
          end else begin
            b = exp_q.pop_front();
            check("beat_id", DW'(out_id), DW'(b.id));
            check("beat_data", out_data, b.data);
          end
        end
        prev_stall = out_valid & ~out_ready;
        prev_data  = out_data;
        prev_id    = out_id;
        if (done) begin
          done_cnt++;
          check("beats_left_at_done", DW'(exp_q.size()), DW'(0));
        end
      end
    end
  end

  task automatic send(input int unsigned row, input logic [31:0] val, input bit last,
                      output int waits);
    @(posedge sys_clk);
    #1;
    in_valid = 1'b1;
    in_row   = RW'(row);
    in_val   = val;
    in_last  = last;
    waits    = 0;
    forever begin
      @(negedge sys_clk);
      if (in_ready) break;
      waits++;
      if (waits > 500) begin
        check("in_ready_timeout", DW'(0), DW'(1));
        break;
      end
    end
  endtask

  task automatic idle_inputs();
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference: lay the accepted values out by row, pad gaps, pad to whole beats, pad to pairs.
  task automatic model_vector(input int n);
    logic [VW-1:0] lanes_q[$];
    int unsigned   e;
    int            nb;
    logic [DW-1:0] d;
    e = 0;
    for (int i = 0; i < n; i++) begin
      if (rows[i] < e) begin
        err_model = 1'b1;
      end else begin
        while (e < rows[i]) begin
          lanes_q.push_back('0);
          e++;
        end
        lanes_q.push_back(vals[i]);
        e++;
      end
    end
    while (lanes_q.size() % LN != 0) lanes_q.push_back('0);
    nb = lanes_q.size() / LN;
    if (nb % 2 != 0) begin
      for (int k = 0; k < LN; k++) lanes_q.push_back('0);
      nb++;
    end
    for (int bi = 0; bi < nb; bi++) begin
      d = '0;
      for (int k = 0; k < LN; k++) d[k*VW +: VW] = lanes_q[bi*LN + k];
      exp_q.push_back({id_ctr, d});
      id_ctr = id_ctr + 8'd1;
    end
  endtask

  task automatic run_vec(input int n, input string name, output int last_waits);
    int target;
    int w;
    int t;
    model_vector(n);
    target     = done_cnt + 1;
    last_waits = 0;
    for (int i = 0; i < n; i++) begin
      send(rows[i], vals[i], (i == n - 1), w);
      last_waits = w;
    end
    idle_inputs();
    t = 0;
    while (done_cnt < target && t < 3000) begin
      @(posedge sys_clk);
      t++;
    end
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check({name, "_done_once"}, DW'(done_cnt), DW'(target));
    check({name, "_beats_drained"}, DW'(exp_q.size()), DW'(0));
    check({name, "_err_seq"}, DW'(err_seq), DW'(err_model));
  endtask

  initial begin
    int w;
    int n;
    int unsigned e;
    in_valid = 1'b1;
    in_row   = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_id", DW'(out_id), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_err_seq", DW'(err_seq), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(0));
    @(posedge sys_clk);
    #1;
    sys_rst  = 1'b0;
    in_valid = 1'b0;

    // 1: two full beats
    for (int i = 0; i < 16; i++) begin rows[i] = i; vals[i] = 32'h100 + i; end
    run_vec(16, "t1", w);
    // 2: partial second beat, already even
    for (int i = 0; i < 10; i++) begin rows[i] = i; vals[i] = 32'h200 + i; end
    run_vec(10, "t2", w);
    // 3: single partial beat plus pair pad
    for (int i = 0; i < 5; i++) begin rows[i] = i; vals[i] = 32'h300 + i; end
    run_vec(5, "t3", w);
    // 4: gap 2..4
    rows[0] = 0; rows[1] = 1; rows[2] = 5;
    vals[0] = 32'h400; vals[1] = 32'h401; vals[2] = 32'h405;
    run_vec(3, "t4", w);
    check("t4_gap_stall", DW'(w >= 3), DW'(1));
    // 5: long output stall
    for (int i = 0; i < 24; i++) begin rows[i] = i; vals[i] = 32'h500 + i; end
    stall_until = cyc + 20;
    run_vec(24, "t5", w);

    // 6: duplicate row, sticky error, then mid-beat reset
    send(0, 32'h600, 1'b0, w);
    send(1, 32'h601, 1'b0, w);
    send(1, 32'h6ff, 1'b0, w);
    send(2, 32'h602, 1'b0, w);
    idle_inputs();
    @(negedge sys_clk);
    check("t6_err_seq_set", DW'(err_seq), DW'(1));
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    check("t6_err_seq_sticky", DW'(err_seq), DW'(1));
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("t6_rst_out_valid", DW'(out_valid), DW'(0));
    check("t6_rst_err_seq", DW'(err_seq), DW'(0));
    check("t6_rst_out_id", DW'(out_id), DW'(0));
    @(posedge sys_clk);
    #1;
    sys_rst   = 1'b0;
    err_model = 1'b0;
    id_ctr    = '0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin rows[i] = i; vals[i] = 32'h700 + i; end
    run_vec(8, "t6_after_rst", w);

    // Random vectors with gaps, duplicates and output back-pressure
    rand_ready = 1'b1;
    for (int v = 0; v < 25; v++) begin
      n = $urandom_range(20, 1);
      e = 0;
      for (int i = 0; i < n; i++) begin
        if (i != n - 1 && e > 0 && $urandom_range(5) == 0) begin
          rows[i] = $urandom_range(e - 1, 0);
        end else begin
          rows[i] = e + (($urandom_range(3) == 0) ? $urandom_range(3, 1) : 0);
          e = rows[i] + 1;
        end
        vals[i] = $urandom;
      end
      run_vec(n, "rand", w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
